// File: rtl/any1_pkg.sv
// Shared definitions for the ANY-1 memory-stage blocks.
package any1_pkg;

  localparam logic [3:0] SZ_BYTE     = 4'd0;
  localparam logic [3:0] SZ_WYDE     = 4'd1;
  localparam logic [3:0] SZ_TETRA    = 4'd2;
  localparam logic [3:0] SZ_OCTA     = 4'd3;
  localparam logic [3:0] SZ_OCTA_ALT = 4'd7;

  localparam int unsigned TMO_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT1,
    ST_BEAT2,
    ST_FIN
  } mem_state_t;

  // Expand an 8-bit byte-lane vector into a 64-bit bit mask.
  function automatic logic [63:0] byte_mask(input logic [7:0] lanes);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{lanes[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/any1_mem_lanes.sv
// Lane mask, shifted store data and size legality for one LDx/STx access.
module any1_mem_lanes
  import any1_pkg::*;
(
  input  logic [3:0]   sz,
  input  logic [2:0]   ofs,
  input  logic [63:0]  dat,
  output logic [15:0]  mask,
  output logic [127:0] sdat,
  output logic         legal
);

  logic [7:0] base;

  // Decode the size code into a base lane mask, then place it at the byte offset.
  always_comb begin
    base  = '0;
    legal = 1'b1;
    case (sz)
      SZ_BYTE:              base = 8'h01;
      SZ_WYDE:              base = 8'h03;
      SZ_TETRA:             base = 8'h0F;
      SZ_OCTA, SZ_OCTA_ALT: base = 8'hFF;
      default:              legal = 1'b0;
    endcase
    mask = {8'h00, base} << ofs;
    sdat = {64'h0, dat} << {ofs, 3'b000};
  end

endmodule

// File: rtl/any1_mem_seq.sv
// Load/store bus sequencer: splits lane-crossing accesses into two aligned beats.
module any1_mem_seq
  import any1_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  sz_i,
  input  logic [31:0] adr_i,
  input  logic [63:0] dat_i,
  output logic        rdy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] res_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [7:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [63:0] dat_o,
  input  logic        ack_i,
  input  logic [63:0] bdat_i
);

  mem_state_t   state_q, state_n;
  logic [7:0]   cnt_q, cnt_n;
  logic [15:0]  mask_q, mask_n;
  logic [2:0]   ofs_q, ofs_n;
  logic [63:0]  hi_q, hi_n;
  logic [127:0] buf_q, buf_n;

  logic         rdy_n, done_n, err_n, cyc_n, stb_n, we_n;
  logic [7:0]   sel_n;
  logic [31:0]  adr_n;
  logic [63:0]  dat_n, res_n;

  logic [15:0]  lmask;
  logic [127:0] lsdat;
  logic         legal;

  logic         ack_ok, fin, abort;
  logic [7:0]   ld_lanes;

  any1_mem_lanes u_lanes (
    .sz    (sz_i),
    .ofs   (adr_i[2:0]),
    .dat   (dat_i),
    .mask  (lmask),
    .sdat  (lsdat),
    .legal (legal)
  );

  // Next-state and next-output logic; every bus output is registered below.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    mask_n   = mask_q;
    ofs_n    = ofs_q;
    hi_n     = hi_q;
    buf_n    = buf_q;
    rdy_n    = rdy_o;
    done_n   = 1'b0;
    err_n    = 1'b0;
    cyc_n    = cyc_o;
    stb_n    = stb_o;
    we_n     = we_o;
    sel_n    = sel_o;
    adr_n    = adr_o;
    dat_n    = dat_o;
    res_n    = res_o;
    fin      = 1'b0;
    abort    = 1'b0;
    ack_ok   = ack_i & stb_o;
    // Stored lane mask shifted back to lane 0 gives the access-size byte mask.
    ld_lanes = 8'(mask_q >> ofs_q);

    case (state_q)
      // FIN already has rdy_o high, so it accepts a new request like IDLE.
      ST_IDLE, ST_FIN: begin
        state_n = ST_IDLE;
        rdy_n   = 1'b1;
        if (req_i && rdy_o) begin
          if (legal) begin
            state_n = ST_BEAT1;
            rdy_n   = 1'b0;
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            we_n    = we_i;
            sel_n   = lmask[7:0];
            adr_n   = {adr_i[31:3], 3'b000};
            dat_n   = lsdat[63:0];
            hi_n    = lsdat[127:64];
            mask_n  = lmask;
            ofs_n   = adr_i[2:0];
            cnt_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        if (ack_ok) begin
          buf_n[63:0] = bdat_i;
          if (mask_q[15:8] != '0) begin
            state_n = ST_BEAT2;
            cnt_n   = '0;
            sel_n   = mask_q[15:8];
            adr_n   = adr_o + 32'd8;
            dat_n   = hi_q;
          end else begin
            fin = 1'b1;
          end
        end else if (cnt_q == 8'(TMO - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      ST_BEAT2: begin
        if (ack_ok) begin
          buf_n[127:64] = bdat_i;
          fin           = 1'b1;
        end else if (cnt_q == 8'(TMO - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (fin || abort) begin
      state_n = fin ? ST_FIN : ST_IDLE;
      rdy_n   = 1'b1;
      cyc_n   = 1'b0;
      stb_n   = 1'b0;
      we_n    = 1'b0;
      sel_n   = '0;
      done_n  = fin;
      err_n   = abort;
    end

    // Load result uses the buffer including the data arriving with the last ack.
    if (fin && !we_o) begin
      res_n = 64'(buf_n >> {ofs_q, 3'b000}) & byte_mask(ld_lanes);
    end
  end

  // State, captured operation context and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      ofs_q   <= '0;
      hi_q    <= '0;
      buf_q   <= '0;
      rdy_o   <= 1'b1;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      res_o   <= '0;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      sel_o   <= '0;
      adr_o   <= '0;
      dat_o   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      mask_q  <= mask_n;
      ofs_q   <= ofs_n;
      hi_q    <= hi_n;
      buf_q   <= buf_n;
      rdy_o   <= rdy_n;
      done_o  <= done_n;
      err_o   <= err_n;
      res_o   <= res_n;
      cyc_o   <= cyc_n;
      stb_o   <= stb_n;
      we_o    <= we_n;
      sel_o   <= sel_n;
      adr_o   <= adr_n;
      dat_o   <= dat_n;
    end
  end

endmodule

// File: tb/tb_any1_mem_seq.sv
// Self-checking bench for any1_mem_seq: vector table, corner sequences, random ops.
module tb_any1_mem_seq;

  localparam int unsigned TMO_TB = 8;

  logic        clk;
  logic        rst_i, req_i, we_i, ack_i;
  logic [3:0]  sz_i;
  logic [31:0] adr_i;
  logic [63:0] dat_i, bdat_i;
  logic        rdy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [63:0] res_o, dat_o;
  logic [7:0]  sel_o;
  logic [31:0] adr_o;

  any1_mem_seq #(.TMO(TMO_TB)) dut (
    .clk_i (clk),   .rst_i (rst_i), .req_i (req_i), .we_i  (we_i),
    .sz_i  (sz_i),  .adr_i (adr_i), .dat_i (dat_i), .rdy_o (rdy_o),
    .done_o(done_o), .err_o(err_o), .res_o (res_o), .cyc_o (cyc_o),
    .stb_o (stb_o), .we_o  (we_o),  .sel_o (sel_o), .adr_o (adr_o),
    .dat_o (dat_o), .ack_i (ack_i), .bdat_i(bdat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] lanes2bits(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Observations from one operation.
  int          o_nb, o_lat;
  logic        o_err, o_done, o_gap, o_rdy, o_cycend;
  logic [7:0]  o_sel [2];
  logic [31:0] o_adr [2];
  logic [63:0] o_dat [2];
  logic        o_we  [2];
  logic [63:0] o_res;

  // Reference expectations.
  int          m_nb;
  logic        m_err;
  logic [7:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [63:0] m_dat [2];
  logic [63:0] m_res;

  // Byte-by-byte reference: each byte of the access lands on one beat and lane.
  task automatic model(input logic we, input logic [3:0] sz, input logic [31:0] adr,
                       input logic [63:0] dat, input logic [63:0] bd0, input logic [63:0] bd1);
    int n, b, lane;
    logic [31:0] a;
    logic [63:0] bd [2];
    bd[0] = bd0; bd[1] = bd1;
    case (sz)
      4'd0: n = 1;
      4'd1: n = 2;
      4'd2: n = 4;
      4'd3, 4'd7: n = 8;
      default: n = 0;
    endcase
    m_err = (n == 0);
    m_sel[0] = '0; m_sel[1] = '0;
    m_dat[0] = '0; m_dat[1] = '0;
    m_res = '0;
    m_adr[0] = adr & ~32'h7;
    m_adr[1] = m_adr[0] + 32'd8;
    for (int i = 0; i < n; i++) begin
      a    = adr + 32'(i);
      b    = (a[31:3] == adr[31:3]) ? 0 : 1;
      lane = int'(a[2:0]);
      m_sel[b][lane] = 1'b1;
      m_dat[b][lane*8 +: 8] = dat[i*8 +: 8];
      m_res[i*8 +: 8] = bd[b][lane*8 +: 8];
    end
    m_nb = m_err ? 0 : ((m_sel[1] != 0) ? 2 : 1);
    if (we) m_res = '0;
  endtask

  // Issue one request and act as the bus slave with the given per-beat ack waits.
  task automatic run_op(input logic we, input logic [3:0] sz, input logic [31:0] adr,
                        input logic [63:0] dat, input logic [63:0] bd0, input logic [63:0] bd1,
                        input int w0, input int w1);
    int wc, nack;
    logic nb_new;
    o_nb = 0; o_lat = 0; o_err = 0; o_done = 0; o_gap = 0; o_rdy = 0; o_cycend = 1;
    o_res = '0;
    for (int i = 0; i < 2; i++) begin
      o_sel[i] = 'x; o_adr[i] = 'x; o_dat[i] = 'x; o_we[i] = 1'bx;
    end
    for (int i = 0; i < 20 && !rdy_o; i++) @(negedge clk);
    req_i = 1'b1; we_i = we; sz_i = sz; adr_i = adr; dat_i = dat;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0; dat_i = {$urandom, $urandom}; adr_i = $urandom;
    wc = 0; nack = 0; nb_new = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      ack_i  = 1'b0;
      bdat_i = {$urandom, $urandom};
      if (done_o || err_o) begin
        o_done = done_o; o_err = err_o; o_lat = k; o_rdy = rdy_o;
        o_res = res_o; o_cycend = cyc_o;
        break;
      end
      if (!cyc_o) o_gap = 1'b1;
      if (stb_o) begin
        if (nb_new) begin
          if (o_nb < 2) begin
            o_sel[o_nb] = sel_o; o_adr[o_nb] = adr_o;
            o_dat[o_nb] = dat_o; o_we[o_nb] = we_o;
          end
          o_nb++;
          nb_new = 1'b0;
        end
        if (wc == ((nack == 0) ? w0 : w1)) begin
          ack_i  = 1'b1;
          bdat_i = (nack == 0) ? bd0 : bd1;
          nack++; nb_new = 1'b1; wc = 0;
        end else begin
          wc++;
        end
      end
      @(negedge clk);
    end
    ack_i = 1'b0;
  endtask

  task automatic verify(input logic e_err, input int e_nb, input logic e_we,
                        input logic [7:0] es0, input logic [7:0] es1,
                        input logic [31:0] ea0, input logic [31:0] ea1,
                        input logic [63:0] ed0, input logic [63:0] ed1,
                        input logic [63:0] er, input int e_lat);
    chk("latency", o_lat, e_lat);
    chk("done_err", {o_done, o_err}, e_err ? 2'b01 : 2'b10);
    chk("rdy_at_end", o_rdy, 1'b1);
    chk("cyc_at_end", o_cycend, 1'b0);
    chk("beats", o_nb, e_nb);
    if (!e_err) begin
      chk("cyc_continuous", o_gap, 1'b0);
      chk("sel0", o_sel[0], es0);
      chk("adr0", o_adr[0], ea0);
      chk("we0", o_we[0], e_we);
      if (e_we) chk("dat0", o_dat[0] & lanes2bits(es0), ed0 & lanes2bits(es0));
      if (e_nb == 2) begin
        chk("sel1", o_sel[1], es1);
        chk("adr1", o_adr[1], ea1);
        chk("we1", o_we[1], e_we);
        if (e_we) chk("dat1", o_dat[1] & lanes2bits(es1), ed1 & lanes2bits(es1));
      end
      if (!e_we) chk("res", o_res, er);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, {rdy_o, done_o, err_o, cyc_o, stb_o, we_o, sel_o, adr_o}, {1'b1, 45'b0});
    chk({tag, "_dat"}, {dat_o, res_o}, 128'b0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sz;
    logic [31:0] adr;
    logic [63:0] dat, bd0, bd1;
    int          w0, w1;
    logic        err;
    int          nb;
    logic [7:0]  s0, s1;
    logic [31:0] a0, a1;
    logic [63:0] d0, d1, res;
  } vec_t;

  vec_t tbl [10];

  initial begin
    vec_t v;
    int lat, w0, w1, fl;
    logic [3:0] sz;
    logic [31:0] adr;
    logic [63:0] dat, bd0, bd1;
    logic we;

    tbl[0] = '{1'b1, 4'd0, 32'h0000_1003, 64'hAB, 64'h0, 64'h0, 0, 0, 1'b0, 1,
               8'h08, 8'h00, 32'h1000, 32'h1008, 64'hAB00_0000, 64'h0, 64'h0};
    tbl[1] = '{1'b0, 4'd2, 32'h0000_1006, 64'h0, 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00,
               0, 0, 1'b0, 2, 8'hC0, 8'h03, 32'h1000, 32'h1008, 64'h0, 64'h0, 64'hFF00_1122};
    tbl[2] = '{1'b0, 4'd3, 32'hFFFF_FFFC, 64'h0, 64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
               2, 1, 1'b0, 2, 8'hF0, 8'h0F, 32'hFFFF_FFF8, 32'h0000_0000, 64'h0, 64'h0,
               64'h1516_1718_0102_0304};
    tbl[3] = '{1'b0, 4'd1, 32'h0000_2001, 64'h0, 64'hFFEE_DDCC_BBAA_9988, 64'h0, 1, 0, 1'b0, 1,
               8'h06, 8'h00, 32'h2000, 32'h2008, 64'h0, 64'h0, 64'hAA99};
    tbl[4] = '{1'b1, 4'd1, 32'h0000_2007, 64'hBEEF, 64'h0, 64'h0, 0, 3, 1'b0, 2,
               8'h80, 8'h01, 32'h2000, 32'h2008, 64'hEF00_0000_0000_0000, 64'hBE, 64'h0};
    tbl[5] = '{1'b0, 4'd7, 32'h0000_3000, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 1'b0, 1,
               8'hFF, 8'h00, 32'h3000, 32'h3008, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF};
    tbl[6] = '{1'b1, 4'd4, 32'h0000_1000, 64'h55, 64'h0, 64'h0, 0, 0, 1'b1, 0,
               8'h00, 8'h00, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0};
    tbl[7] = '{1'b0, 4'hF, 32'h0000_1005, 64'h0, 64'h0, 64'h0, 0, 0, 1'b1, 0,
               8'h00, 8'h00, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0};
    tbl[8] = '{1'b1, 4'd2, 32'h0000_4004, 64'hDEAD_BEEF, 64'h0, 64'h0, 2, 0, 1'b0, 1,
               8'hF0, 8'h00, 32'h4000, 32'h4008, 64'hDEAD_BEEF_0000_0000, 64'h0, 64'h0};
    tbl[9] = '{1'b1, 4'd3, 32'h0000_5003, 64'h0807_0605_0403_0201, 64'h0, 64'h0, 1, 1, 1'b0, 2,
               8'hF8, 8'h07, 32'h5000, 32'h5008, 64'h0504_0302_0100_0000, 64'h0807_06, 64'h0};

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; ack_i = 1'b0;
    sz_i = '0; adr_i = '0; dat_i = '0; bdat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_i = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      v = tbl[i];
      run_op(v.we, v.sz, v.adr, v.dat, v.bd0, v.bd1, v.w0, v.w1);
      lat = v.err ? 1 : 1 + v.nb + v.w0 + ((v.nb == 2) ? v.w1 : 0);
      verify(v.err, v.nb, v.we, v.s0, v.s1, v.a0, v.a1, v.d0, v.d1, v.res, lat);
    end

    // Timeout in the first beat, then in the second beat; each followed by a normal op.
    run_op(1'b0, 4'd2, 32'h6000, 64'h0, 64'h0, 64'h0, 1000, 0);
    verify(1'b1, 1, 1'b0, 0, 0, 0, 0, 0, 0, 0, TMO_TB + 1);
    model(1'b0, 4'd1, 32'h6002, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0);
    run_op(1'b0, 4'd1, 32'h6002, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 0);
    verify(m_err, m_nb, 1'b0, m_sel[0], m_sel[1], m_adr[0], m_adr[1], m_dat[0], m_dat[1], m_res, 2);
    run_op(1'b1, 4'd3, 32'h7004, 64'h1, 64'h0, 64'h0, 0, 1000);
    verify(1'b1, 2, 1'b1, 0, 0, 0, 0, 0, 0, 0, 2 + TMO_TB);

    // Reset during the second beat aborts silently.
    for (int i = 0; i < 20 && !rdy_o; i++) @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; sz_i = 4'd2; adr_i = 32'h1006;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0; ack_i = 1'b1; bdat_i = 64'h1122_3344_5566_7788;
    @(negedge clk);
    ack_i = 1'b0;
    chk("beat2_before_rst", {cyc_o, stb_o, sel_o, adr_o}, {1'b1, 1'b1, 8'h03, 32'h1008});
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset("mid_rst");
    fl = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o || err_o) fl = 1;
    end
    chk("no_pulse_after_rst", fl, 0);
    model(1'b0, 4'd2, 32'h1006, 64'h0, 64'hA1A2_A3A4_A5A6_A7A8, 64'hB1B2_B3B4_B5B6_B7B8);
    run_op(1'b0, 4'd2, 32'h1006, 64'h0, 64'hA1A2_A3A4_A5A6_A7A8, 64'hB1B2_B3B4_B5B6_B7B8, 0, 0);
    verify(m_err, m_nb, 1'b0, m_sel[0], m_sel[1], m_adr[0], m_adr[1], m_dat[0], m_dat[1], m_res, 3);

    // Randomised operations against the byte-level reference.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 10))
        0, 1:    sz = 4'd0;
        2, 3:    sz = 4'd1;
        4, 5:    sz = 4'd2;
        6, 7:    sz = 4'd3;
        8, 9:    sz = 4'd7;
        default: begin
          sz = 4'($urandom_range(4, 15));
          if (sz == 4'd7) sz = 4'd5;
        end
      endcase
      adr = $urandom;
      if ($urandom_range(0, 7) == 0) adr = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      we  = 1'($urandom);
      dat = {$urandom, $urandom};
      bd0 = {$urandom, $urandom};
      bd1 = {$urandom, $urandom};
      w0  = $urandom_range(0, 3);
      w1  = $urandom_range(0, 3);
      model(we, sz, adr, dat, bd0, bd1);
      run_op(we, sz, adr, dat, bd0, bd1, w0, w1);
      lat = m_err ? 1 : 1 + m_nb + w0 + ((m_nb == 2) ? w1 : 0);
      verify(m_err, m_nb, we, m_sel[0], m_sel[1], m_adr[0], m_adr[1], m_dat[0], m_dat[1], m_res, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
